reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Hazard scoreboard that sequences access to the 11-entry register file: general R0–R7 plus SP, IH and T. It sits beside the ID stage of the 5-stage pipeline (IF/ID/EX/MEM/WB) and tracks every in-flight register write until its WB-stage negedge write completes. From that state it drives the ID stall, the per-operand forwarding selects, and a stall statistics counter. It also exports a busy mask for the debug display.

## Interface
- FORWARD, 1, 1 means EX/MEM and MEM/WB bypass paths exist; 0 means no bypass, so every RAW hazard stalls.
- CLK  in  1  pipeline clock; all state updates on posedge.
- RST  in  1  asynchronous, active-low reset.
- hold  in  1  global pipeline freeze (memory structural stall); the scoreboard is frozen while it is high.
- flush  in  1  the ID instruction is being squashed this cycle.
- id_valid  in  1  the ID stage holds a real instruction.
- id_src1_used / id_src2_used  in  1 each  operand 1 / operand 2 is read.
- id_src1_spec  in  2  readSpecReg encoding for operand 1: 00 = general, 01 = SP, 10 = IH, 11 = T.
- id_src1 / id_src2  in  3 each  general register indices; operand 2 is always a general register.
- id_regWrite  in  1  the ID instruction writes a register.
- id_dst_spec  in  2  writeSpecReg encoding for the destination.
- id_dst  in  3  destination general register index.
- id_memRead  in  1  the ID instruction is a load.
- stall  out  1  hold PC and IF/ID, and inject a bubble into EX.
- fwd_sel1 / fwd_sel2  out  2 each  operand source: 00 = register file, 01 = EX result, 10 = MEM result.
- busy_mask  out  11  bit i is set when entry i has a pending write. Bits 0–7 are R0–R7, bit 8 is SP, bit 9 is IH, bit 10 is T.
- stall_count  out  16  saturating count of stall cycles.

## Operation
- Register id mapping: if spec = 00, id = {0, idx}; otherwise id = 7 + spec, giving 8, 9 or 10.
- Per-entry state: cnt[1:0] and ld (load flag). Reset values: cnt = 0, ld = 0, stall_count = 0.
- At reset, busy_mask = 0, stall = 0 and fwd_sel = 00.
- Issue condition: issue = id_valid & id_regWrite & ~stall & ~hold & ~flush.
- On issue, the destination entry is loaded with cnt = 3 and ld = id_memRead.
  - This overwrites any pending count on that entry (WAW is safe because the pipeline is in order).
- Every cycle with hold = 0, each entry with cnt ≠ 0 decrements, unless the same cycle's issue reloads that entry.
- Cnt meaning: 3 = producer in EX, 2 = in MEM, 1 = in WB (the register file writes on the negedge, so the value is readable), 0 = idle.
- Hazard for an operand = used & (cnt[src] ≥ 2). The condition is evaluated combinationally on the current state; the same instruction's own issue is never included.
- Stall condition:
  - FORWARD = 0: stall = id_valid & ~flush & (any operand hazard).
  - FORWARD = 1: stall = id_valid & ~flush & any used operand with cnt[src] = 3 and ld = 1 (load-use). Every other hazard is bypassed.
- Forwarding selects:
  - With FORWARD = 1 and no stall: fwd_sel = 01 if cnt = 3, 10 if cnt = 2, else 00.
  - fwd_sel = 00 whenever FORWARD = 0, stall = 1, or the operand is unused.
- stall_count increments on each posedge where stall = 1 and hold = 0, and saturates at 16'hFFFF.
- busy_mask[i] = (cnt[i] ≠ 0).

## Timing
- Issue at cycle t: cnt = 3 during t+1, 2 during t+2, 1 during t+3, and 0 from t+4.
- stall, fwd_sel and busy_mask are combinational from the registered state and the ID inputs, with zero latency.
- A load-use stall lasts exactly 1 cycle with FORWARD = 1. A back-to-back RAW stall lasts 2 cycles with FORWARD = 0.
- While hold is high, all state is frozen, no issue occurs, and stall_count does not increment. stall may still assert.
- When flush and a hazard coincide, flush wins: stall = 0 and no issue.
- Reset asserted mid-operation clears all entries immediately and asynchronously.
- Destination and source the same register within one instruction: there is no self-hazard, and the entry is loaded after the check.

## Structure
- Shared package contents:
  - Register-id constants: ID_SP = 8, ID_IH = 9, ID_T = 10, NUM_REGS = 11.
  - Cnt constants: CNT_EX = 3, CNT_MEM = 2.
  - fwd_sel encodings.
  - Function reg_id(spec, idx).
- One natural sub-module, sb_entry: the per-register cnt/ld counter with load, decrement and hold. It is instantiated 11 times.

## Test plan
- Reset then idle: busy_mask = 0, stall = 0, stall_count = 0. Issue a write to R3, then keep id_valid low so the ID stage is idle: busy_mask = 11'h008 for exactly 3 cycles, then 0.
- FORWARD = 1: ADD to R2, followed by a reader of R2 via src2. The next cycle shows fwd_sel2 = 01, the cycle after shows 10, and stall stays 0 throughout.
- FORWARD = 1: load to R5 (id_memRead = 1), followed by a reader of R5. stall = 1 for exactly one cycle, then fwd_sel = 10, and stall_count = 1.
- FORWARD = 0: write to SP (dst_spec = 01), followed by a reader with src1_spec = 01. Stall lasts 2 cycles, the third cycle proceeds with fwd_sel1 = 00, and stall_count = 2.
- Hazard with flush = 1: stall = 0, no issue, and busy_mask is unchanged. Hazard with hold = 1 for 4 cycles: cnt is frozen and stall_count is unchanged.
- Assert RST low while entries 0, 8 and 10 are busy: busy_mask = 0 immediately, with no clock edge needed. Separately, force 65,536 stall cycles: stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register-file hazard scoreboard: register ids,
// pipeline-stage count values, forwarding encodings and the id mapping helper.
package reg_scoreboard_pkg;

   localparam int unsigned NUM_REGS = 11;
   localparam int unsigned ID_W     = 4;

   localparam logic [ID_W-1:0] ID_SP = 4'd8;
   localparam logic [ID_W-1:0] ID_IH = 4'd9;
   localparam logic [ID_W-1:0] ID_T  = 4'd10;

   localparam logic [1:0] CNT_EX   = 2'd3;
   localparam logic [1:0] CNT_MEM  = 2'd2;
   localparam logic [1:0] CNT_IDLE = 2'd0;

   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      SPEC_GEN = 2'b00,
      SPEC_SP  = 2'b01,
      SPEC_IH  = 2'b10,
      SPEC_T   = 2'b11
   } spec_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // Per-operand lookup result gathered from the entry array.
   typedef struct packed {
      logic       used;
      logic [1:0] cnt;
      logic       ld;
   } operand_t;

   function automatic logic [ID_W-1:0] reg_id(input logic [1:0] spec,
                                              input logic [2:0] idx);
      logic [ID_W-1:0] id;
      if (spec == SPEC_GEN) begin
         id = {1'b0, idx};
      end else begin
         id = 4'd7 + {2'b00, spec};
      end
      return id;
   endfunction

endpackage

// File: rtl/reg_scoreboard_entry.sv
// One scoreboard entry: pending-write countdown plus load flag for a single
// architectural register. Reload wins over decrement; hold freezes everything.
module sb_entry
   import reg_scoreboard_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       hold_i,
   input  logic       load_i,
   input  logic       ld_i,
   output logic [1:0] cnt_o,
   output logic       ld_o
);

   logic [1:0] cnt_d, cnt_q;
   logic       ld_d, ld_q;

   always_comb begin
      cnt_d = cnt_q;
      ld_d  = ld_q;
      if (!hold_i) begin
         if (load_i) begin
            cnt_d = CNT_EX;
            ld_d  = ld_i;
         end else if (cnt_q != CNT_IDLE) begin
            cnt_d = cnt_q - 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= CNT_IDLE;
         ld_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ld_q  <= ld_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ld_o  = ld_q;

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage hazard scoreboard for the 11-entry register file: tracks in-flight
// writes and derives stall, per-operand forwarding selects and stall statistics.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter bit FORWARD = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        hold,
   input  logic        flush,
   input  logic        id_valid,
   input  logic        id_src1_used,
   input  logic        id_src2_used,
   input  logic [1:0]  id_src1_spec,
   input  logic [2:0]  id_src1,
   input  logic [2:0]  id_src2,
   input  logic        id_regWrite,
   input  logic [1:0]  id_dst_spec,
   input  logic [2:0]  id_dst,
   input  logic        id_memRead,
   output logic        stall,
   output logic [1:0]  fwd_sel1,
   output logic [1:0]  fwd_sel2,
   output logic [10:0] busy_mask,
   output logic [15:0] stall_count
);

   logic [1:0]      cnt [NUM_REGS];
   logic            ld  [NUM_REGS];
   logic [ID_W-1:0] src1_id, src2_id, dst_id;
   operand_t        op1, op2;
   logic            haz1, haz2, lu1, lu2;
   logic            issue;
   logic [15:0]     stall_count_d, stall_count_q;

   assign src1_id = reg_id(id_src1_spec, id_src1);
   assign src2_id = reg_id(SPEC_GEN, id_src2);
   assign dst_id  = reg_id(id_dst_spec, id_dst);

   always_comb begin
      op1.used = id_src1_used;
      op1.cnt  = cnt[src1_id];
      op1.ld   = ld[src1_id];
      op2.used = id_src2_used;
      op2.cnt  = cnt[src2_id];
      op2.ld   = ld[src2_id];
   end

   // Hazards look only at registered state, so an instruction never sees its own issue.
   assign haz1 = op1.used && (op1.cnt >= CNT_MEM);
   assign haz2 = op2.used && (op2.cnt >= CNT_MEM);
   assign lu1  = op1.used && (op1.cnt == CNT_EX) && op1.ld;
   assign lu2  = op2.used && (op2.cnt == CNT_EX) && op2.ld;

   always_comb begin
      stall = 1'b0;
      if (id_valid && !flush) begin
         if (FORWARD) begin
            stall = lu1 || lu2;
         end else begin
            stall = haz1 || haz2;
         end
      end
   end

   function automatic logic [1:0] fwd_of(input operand_t op, input logic stalled);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (FORWARD && !stalled && op.used) begin
         if (op.cnt == CNT_EX) begin
            sel = FWD_EX;
         end else if (op.cnt == CNT_MEM) begin
            sel = FWD_MEM;
         end
      end
      return sel;
   endfunction

   assign fwd_sel1 = fwd_of(op1, stall);
   assign fwd_sel2 = fwd_of(op2, stall);

   assign issue = id_valid && id_regWrite && !stall && !hold && !flush;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
      sb_entry u_entry (
         .clk_i  (CLK),
         .rst_ni (RST),
         .hold_i (hold),
         .load_i (issue && (dst_id == ID_W'(g))),
         .ld_i   (id_memRead),
         .cnt_o  (cnt[g]),
         .ld_o   (ld[g])
      );
      assign busy_mask[g] = (cnt[g] != CNT_IDLE);
   end

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && !hold && (stall_count_q != STALL_CNT_MAX)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: FORWARD=0 and FORWARD=1 scoreboards share one stimulus
// stream and are compared against a pipeline-age reference model.
module tb_reg_scoreboard;

   logic CLK = 1'b0;
   logic RST;
   logic hold, flush, id_valid, id_src1_used, id_src2_used;
   logic [1:0] id_src1_spec, id_dst_spec;
   logic [2:0] id_src1, id_src2, id_dst;
   logic id_regWrite, id_memRead;

   // index 0: FORWARD=0, index 1: FORWARD=1
   logic [1:0]        st;
   logic [1:0][1:0]   f1, f2;
   logic [1:0][10:0]  bm;
   logic [1:0][15:0]  sc;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Model: age = posedges (outside hold) since the latest write issued to that
   // register; 1 = producer in EX, 2 = MEM, 3 = WB, 4 = retired.
   int          age  [2][11];
   bit          mld  [2][11];
   int unsigned mcnt [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      reg_scoreboard #(.FORWARD(gi == 1)) u_dut (
         .CLK          (CLK),
         .RST          (RST),
         .hold         (hold),
         .flush        (flush),
         .id_valid     (id_valid),
         .id_src1_used (id_src1_used),
         .id_src2_used (id_src2_used),
         .id_src1_spec (id_src1_spec),
         .id_src1      (id_src1),
         .id_src2      (id_src2),
         .id_regWrite  (id_regWrite),
         .id_dst_spec  (id_dst_spec),
         .id_dst       (id_dst),
         .id_memRead   (id_memRead),
         .stall        (st[gi]),
         .fwd_sel1     (f1[gi]),
         .fwd_sel2     (f2[gi]),
         .busy_mask    (bm[gi]),
         .stall_count  (sc[gi])
      );
   end

   initial forever #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int id_of(input logic [1:0] spec, input logic [2:0] idx);
      return (spec == 2'b00) ? int'(idx) : 7 + int'(spec);
   endfunction

   function automatic bit m_stall(input int i);
      int a1, a2;
      bit l1, l2;
      a1 = age[i][id_of(id_src1_spec, id_src1)];
      a2 = age[i][id_of(2'b00, id_src2)];
      l1 = mld[i][id_of(id_src1_spec, id_src1)];
      l2 = mld[i][id_of(2'b00, id_src2)];
      if (!id_valid || flush) return 1'b0;
      if (i == 1) return (id_src1_used && a1 == 1 && l1) || (id_src2_used && a2 == 1 && l2);
      return (id_src1_used && a1 <= 2) || (id_src2_used && a2 <= 2);
   endfunction

   function automatic logic [1:0] m_fwd(input int i, input logic used, input int rid);
      if (i == 0 || !used || m_stall(i)) return 2'b00;
      if (age[i][rid] == 1) return 2'b01;
      if (age[i][rid] == 2) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [10:0] m_busy(input int i);
      logic [10:0] m;
      m = '0;
      for (int r = 0; r < 11; r++) m[r] = (age[i][r] <= 3);
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 11; r++) begin
            age[i][r] = 4;
            mld[i][r] = 1'b0;
         end
         mcnt[i] = 0;
      end
   endtask

   task automatic verify();
      #1;
      for (int i = 0; i < 2; i++) begin
         check_eq(i ? "stall_f1" : "stall_f0", 32'(st[i]), 32'(m_stall(i)));
         check_eq(i ? "fwd1_f1"  : "fwd1_f0",  32'(f1[i]),
                  32'(m_fwd(i, id_src1_used, id_of(id_src1_spec, id_src1))));
         check_eq(i ? "fwd2_f1"  : "fwd2_f0",  32'(f2[i]),
                  32'(m_fwd(i, id_src2_used, id_of(2'b00, id_src2))));
         check_eq(i ? "busy_f1"  : "busy_f0",  32'(bm[i]), 32'(m_busy(i)));
         check_eq(i ? "scnt_f1"  : "scnt_f0",  32'(sc[i]), mcnt[i]);
      end
   endtask

   task automatic step();
      bit s [2];
      bit iss [2];
      for (int i = 0; i < 2; i++) begin
         s[i]   = m_stall(i);
         iss[i] = id_valid && id_regWrite && !s[i] && !hold && !flush;
      end
      @(posedge CLK);
      if (!hold) begin
         for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 11; r++) if (age[i][r] < 4) age[i][r]++;
            if (iss[i]) begin
               age[i][id_of(id_dst_spec, id_dst)] = 1;
               mld[i][id_of(id_dst_spec, id_dst)] = id_memRead;
            end
            if (s[i] && mcnt[i] < 65535) mcnt[i]++;
         end
      end
      @(negedge CLK);
   endtask

   task automatic tick();
      verify();
      step();
   endtask

   task automatic set_id(input logic v, input logic u1, input logic [1:0] sp1, input logic [2:0] s1,
                         input logic u2, input logic [2:0] s2, input logic rw,
                         input logic [1:0] dsp, input logic [2:0] d, input logic mr);
      id_valid = v;  id_src1_used = u1; id_src1_spec = sp1; id_src1 = s1;
      id_src2_used = u2; id_src2 = s2; id_regWrite = rw; id_dst_spec = dsp;
      id_dst = d; id_memRead = mr;
   endtask

   task automatic do_reset();
      RST = 1'b0;
      hold = 1'b0;
      flush = 1'b0;
      set_id(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      do_reset();
      verify();
      for (int i = 0; i < 2; i++) begin
         check_eq("rst_busy", 32'(bm[i]), 32'h0);
         check_eq("rst_stall", 32'(st[i]), 32'h0);
         check_eq("rst_scnt", 32'(sc[i]), 32'h0);
      end

      // Single write to R3, ID idle afterwards
      set_id(1, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'd3, 0);
      tick();
      set_id(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
      for (int k = 0; k < 4; k++) begin
         verify();
         check_eq("r3_busy", 32'(bm[1]), (k < 3) ? 32'h008 : 32'h000);
         check_eq("r3_busy", 32'(bm[0]), (k < 3) ? 32'h008 : 32'h000);
         step();
      end

      // ALU result forwarded to src2 from EX then MEM
      do_reset();
      set_id(1, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'd2, 0);
      tick();
      set_id(1, 0, 2'b00, 0, 1, 3'd2, 0, 2'b00, 0, 0);
      verify();
      check_eq("add_fwd_ex", 32'(f2[1]), 32'h1);
      check_eq("add_nostall", 32'(st[1]), 32'h0);
      step();
      verify();
      check_eq("add_fwd_mem", 32'(f2[1]), 32'h2);
      check_eq("add_nostall", 32'(st[1]), 32'h0);
      step();
      verify();
      check_eq("add_fwd_rf", 32'(f2[1]), 32'h0);
      step();

      // Load-use with bypass: one stall then MEM forward
      do_reset();
      set_id(1, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'd5, 1);
      tick();
      set_id(1, 1, 2'b00, 3'd5, 0, 0, 0, 2'b00, 0, 0);
      verify();
      check_eq("lu_stall", 32'(st[1]), 32'h1);
      step();
      verify();
      check_eq("lu_release", 32'(st[1]), 32'h0);
      check_eq("lu_fwd_mem", 32'(f1[1]), 32'h2);
      check_eq("lu_scnt", 32'(sc[1]), 32'h1);
      step();

      // No bypass: SP write then SP reader stalls twice
      do_reset();
      set_id(1, 0, 2'b00, 0, 0, 0, 1, 2'b01, 0, 0);
      tick();
      set_id(1, 1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 0);
      verify();
      check_eq("sp_stall0", 32'(st[0]), 32'h1);
      step();
      verify();
      check_eq("sp_stall1", 32'(st[0]), 32'h1);
      step();
      verify();
      check_eq("sp_go", 32'(st[0]), 32'h0);
      check_eq("sp_fwd_rf", 32'(f1[0]), 32'h0);
      check_eq("sp_scnt", 32'(sc[0]), 32'h2);
      step();

      // Flush beats hazard; then hold freezes state
      do_reset();
      set_id(1, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'd4, 0);
      tick();
      flush = 1'b1;
      set_id(1, 1, 2'b00, 3'd4, 0, 0, 1, 2'b00, 3'd6, 0);
      verify();
      check_eq("flush_stall", 32'(st[0]), 32'h0);
      check_eq("flush_stall", 32'(st[1]), 32'h0);
      step();
      flush = 1'b0;
      hold = 1'b1;
      for (int k = 0; k < 4; k++) begin
         verify();
         check_eq("hold_busy", 32'(bm[0]), 32'h010);
         check_eq("hold_stall", 32'(st[0]), 32'h1);
         check_eq("hold_scnt", 32'(sc[0]), 32'h0);
         step();
      end
      hold = 1'b0;
      tick();
      verify();
      check_eq("unhold_scnt", 32'(sc[0]), 32'h1);
      step();

      // Asynchronous reset with R0, SP and T pending
      do_reset();
      set_id(1, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'd0, 0);
      tick();
      set_id(1, 0, 2'b00, 0, 0, 0, 1, 2'b01, 3'd0, 0);
      tick();
      set_id(1, 0, 2'b00, 0, 0, 0, 1, 2'b11, 3'd0, 0);
      tick();
      set_id(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
      verify();
      check_eq("pre_rst_busy", 32'(bm[0]), 32'h501);
      check_eq("pre_rst_busy", 32'(bm[1]), 32'h501);
      #1 RST = 1'b0;
      #1;
      model_reset();
      check_eq("async_rst_busy", 32'(bm[0]), 32'h0);
      check_eq("async_rst_busy", 32'(bm[1]), 32'h0);
      @(negedge CLK);
      RST = 1'b1;

      // Randomized traffic over a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         hold  = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 7) == 0);
         set_id($urandom_range(0, 5) != 0, 1'($urandom), 2'($urandom), 3'($urandom_range(0, 3)),
                1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                2'($urandom), 3'($urandom_range(0, 3)), 1'($urandom));
         tick();
      end

      // Saturation: self-dependent R1 writer stalls two of every three cycles
      do_reset();
      set_id(1, 1, 2'b00, 3'd1, 0, 0, 1, 2'b00, 3'd1, 0);
      for (int c = 0; c < 99000 && mcnt[0] < 65535; c++) step();
      for (int k = 0; k < 4; k++) begin
         verify();
         check_eq("sat_scnt", 32'(sc[0]), 32'hFFFF);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
